seq_mult: RTL and testbench
===========================

# seq_mult

Parametrised sequential shift-add multiplier with a start/done handshake. It produces the full 2*WIDTH-bit product and supports both unsigned and two's-complement operands. It is the datapath block other FSM-driven units in the design instantiate when they need a multiply and can tolerate a fixed multi-cycle latency. One radix-2 iteration runs per clock, so area stays small at the cost of WIDTH cycles per operation.

## Interface
- WIDTH, default 4: operand width in bits; legal values are 2 or greater.
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- start  input  1  request. Sampled only in IDLE.
- signed_mode  input  1  1 = x and y are two's-complement; 0 = unsigned. Sampled with start.
- x  input  WIDTH  multiplicand. Sampled with start.
- y  input  WIDTH  multiplier. Sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; high only in DONE.
- product  output  2*WIDTH  registered result, held until the next result is written.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1; otherwise stay in IDLE.
  - RUN -> DONE when the iteration counter reaches WIDTH; otherwise stay in RUN.
  - DONE -> IDLE unconditionally.
- Capture, on the edge leaving IDLE:
  - M <= |x|, Q <= |y|, A <= 0, cnt <= 0.
  - neg <= signed_mode & (x[MSB] ^ y[MSB]).
  - Magnitudes are taken only when signed_mode=1 and the MSB is set. Otherwise the operand is used as-is.
  - A magnitude is WIDTH-bit unsigned, so the most-negative value (e.g. -8 at WIDTH=4) maps to 8 without overflow.
- Registers: A is WIDTH+1 bits, Q is WIDTH bits, cnt is clog2(WIDTH+1) bits.
- Each RUN edge:
  - If Q[0]=1, sum = A + M (WIDTH+1 bits, no truncation); else sum = A.
  - {A,Q} <= {sum,Q} >> 1, with 0 shifted into the MSB of A.
  - cnt <= cnt + 1.
- Final result: raw = {A[WIDTH-1:0], Q}. At the RUN->DONE edge, product <= neg ? (~raw + 1) : raw, truncated to 2*WIDTH bits.
- The result is exact for all operand pairs in both modes. Worst signed case (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits.
- product is written only at the RUN->DONE edge.
- Rules for start:
  - start in RUN or DONE is ignored; there is no queueing and no abort.
  - start held high continuously gives back-to-back operations, each WIDTH+2 cycles long.
- x, y and signed_mode may change freely after capture; they have no effect until the next capture.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, busy=0, done=0, product=0, A=Q=M=cnt=neg=0.
- Reset mid-operation aborts the operation. No done pulse is produced and product reads 0.
- Reset release is synchronous to the clock. start is first sampled on the first rising edge with rst_in=1.
- Call the capture edge E0:
  - busy=1 from after E0 through after E(WIDTH-1).
  - E(WIDTH) is the RUN->DONE edge: product is updated there and done=1 for exactly one cycle after it.
  - E(WIDTH+1) returns the FSM to IDLE, with done=0 and busy=0.
- Latency: done asserts WIDTH cycles after the capture edge.
- Issue interval: WIDTH+2 cycles minimum (capture edge to next capture edge).
- product is valid from the cycle done is high and stays stable until the next RUN->DONE edge or a reset.
- busy and done are never high together. done is never high for two consecutive cycles.

## Test plan
- Reset/idle: assert rst_in=0 mid-simulation -> busy=0, done=0, product=0 immediately, with no clock edge needed.
- Unsigned max, WIDTH=4: x=15, y=15, signed_mode=0, pulse start -> done exactly 4 cycles after the capture edge, product=0xE1 (225), busy high for 4 cycles.
- Signed corner cases, WIDTH=4:
  - x=0x8, y=0x8 -> 0x0040 (+64).
  - x=0xD, y=0x5 -> 0xF1 (-15).
  - x=0x7, y=0x0 -> 0x00.
- Busy rules: start pulsed during RUN with different operands -> ignored; the first result is reported and done pulses only once. Then hold start=1 -> the next capture edge lands exactly 6 cycles after the previous capture.
- Abort: pull rst_in low at cycle 2 of RUN, then release -> no done pulse, product=0. A following 3*5 -> 15.
- WIDTH=8 instance:
  - x=255, y=255 unsigned -> 0xFE01.
  - x=0x80, y=0x7F signed -> 0xC080 (-16256), done 8 cycles after capture.
- Random regression: ≥1000 random operand and mode pairs per WIDTH in {4, 8}, checked against a reference multiply.

Source files
------------

// File: rtl/seq_mult_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The requester drives start and the operands; the multiplier answers with busy, done and product.
interface seq_mult_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, x, y,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, x, y,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult.sv
// Radix-2 shift-add multiplier, one iteration per clock, full 2*WIDTH-bit product.
// Signed operands are multiplied as magnitudes and the sign is reapplied to the final result.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    seq_mult_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      ONE_C    = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P    = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     x_mag, y_mag;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       a_sh;
    logic [WIDTH-1:0]     q_sh;
    logic [2*WIDTH-1:0]   raw_w;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        // The most-negative operand negates to itself, which read as unsigned is its magnitude.
        x_mag = (bus.signed_mode && bus.x[WIDTH-1]) ? (~bus.x + ONE_W) : bus.x;
        y_mag = (bus.signed_mode && bus.y[WIDTH-1]) ? (~bus.y + ONE_W) : bus.y;

        sum_w = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
        a_sh  = {1'b0, sum_w[WIDTH:1]};
        q_sh  = {sum_w[0], q_q[WIDTH-1:1]};
        // The last iteration's shifted value feeds the result directly so product lands on the RUN->DONE edge.
        raw_w = {a_sh[WIDTH-1:0], q_sh};

        bus.busy    = (state_q == RUN);
        bus.done    = (state_q == DONE);
        bus.product = product_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    m_d     = x_mag;
                    q_d     = y_mag;
                    a_d     = '0;
                    cnt_d   = '0;
                    neg_d   = bus.signed_mode & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
                end
            end
            RUN: begin
                a_d   = a_sh;
                q_d   = q_sh;
                cnt_d = cnt_q + ONE_C;
                if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    product_d = neg_q ? (~raw_w + ONE_P) : raw_w;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult at WIDTH=4 and WIDTH=8: directed corners plus random regression.
// Expected products come from a plain integer multiply of the sign-interpreted operands.
module tb_seq_mult;
    logic clk;
    logic rst_n;
    int   check_cnt;
    int   pass_cnt;

    seq_mult_if #(.WIDTH(4)) bus4 ();
    seq_mult_if #(.WIDTH(8)) bus8 ();

    seq_mult #(.WIDTH(4)) dut4 (.clk_in(clk), .rst_in(rst_n), .bus(bus4.slave));
    seq_mult #(.WIDTH(8)) dut8 (.clk_in(clk), .rst_in(rst_n), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input int w, input bit sm, input int xv, input int yv);
        longint a;
        longint b;
        longint p;
        a = longint'(xv);
        b = longint'(yv);
        if (sm && xv[w-1]) a = a - (longint'(1) << w);
        if (sm && yv[w-1]) b = b - (longint'(1) << w);
        p = (a * b) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    task automatic drive(input int w, input bit st, input bit sm, input int xv, input int yv);
        if (w == 4) begin
            bus4.start = st; bus4.signed_mode = sm; bus4.x = xv[3:0]; bus4.y = yv[3:0];
        end else begin
            bus8.start = st; bus8.signed_mode = sm; bus8.x = xv[7:0]; bus8.y = yv[7:0];
        end
    endtask

    function automatic logic obs_busy(input int w);
        return (w == 4) ? bus4.busy : bus8.busy;
    endfunction

    function automatic logic obs_done(input int w);
        return (w == 4) ? bus4.done : bus8.done;
    endfunction

    function automatic logic [31:0] obs_prod(input int w);
        return (w == 4) ? 32'(bus4.product) : 32'(bus8.product);
    endfunction

    // Issue one operation from IDLE and check latency, product and (optionally) busy/done shape.
    task automatic run_op(input int w, input bit sm, input int xv, input int yv,
                          input string tag, input bit full);
        int lat;
        int busy_n;
        int overlap;
        logic [31:0] exp;
        exp = model(w, sm, xv, yv);
        @(negedge clk);
        drive(w, 1'b1, sm, xv, yv);
        @(negedge clk);
        drive(w, 1'b0, ~sm, int'($urandom), int'($urandom));
        lat = -1; busy_n = 0; overlap = 0;
        for (int c = 0; c < w + 4; c++) begin
            if (c > 0) @(negedge clk);
            if (obs_busy(w) && obs_done(w)) overlap++;
            if (obs_busy(w)) busy_n++;
            if (obs_done(w)) begin
                lat = c;
                break;
            end
        end
        $display("op %s w=%0d sm=%0d x=0x%0h y=0x%0h -> product 0x%0h latency %0d",
                 tag, w, sm, xv, yv, obs_prod(w), lat);
        chk({tag, "_latency"}, 32'(lat), 32'(w));
        chk({tag, "_product"}, obs_prod(w), exp);
        if (full) begin
            chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(w));
            chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
            @(negedge clk);
            chk({tag, "_done_single"}, 32'(obs_done(w)), 32'd0);
            chk({tag, "_busy_after"}, 32'(obs_busy(w)), 32'd0);
            chk({tag, "_product_held"}, obs_prod(w), exp);
        end
    endtask

    initial begin
        int done_n;
        int rise0;
        int rise1;
        logic prev_busy;
        logic [31:0] prod_at_done;

        check_cnt = 0;
        pass_cnt  = 0;
        rst_n = 1'b0;
        drive(4, 1'b0, 1'b0, 0, 0);
        drive(8, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_busy4", 32'(bus4.busy), 32'd0);
        chk("reset_done4", 32'(bus4.done), 32'd0);
        chk("reset_prod4", 32'(bus4.product), 32'd0);
        chk("reset_prod8", 32'(bus8.product), 32'd0);
        rst_n = 1'b1;

        run_op(4, 1'b0, 15, 15, "u4_max", 1'b1);
        chk("u4_max_const", obs_prod(4), 32'hE1);
        run_op(4, 1'b1, 8, 8, "s4_minmin", 1'b1);
        chk("s4_minmin_const", obs_prod(4), 32'h40);
        run_op(4, 1'b1, 13, 5, "s4_neg15", 1'b1);
        chk("s4_neg15_const", obs_prod(4), 32'hF1);
        run_op(4, 1'b1, 7, 0, "s4_zero", 1'b1);

        // start pulsed during RUN must be ignored
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 2, 3);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 5, 7);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 0, 0);
        done_n = 0; prod_at_done = '1;
        for (int c = 0; c < 12; c++) begin
            if (bus4.done) begin
                done_n++;
                prod_at_done = 32'(bus4.product);
            end
            @(negedge clk);
        end
        $display("op ignore_start w=4 done pulses %0d product 0x%0h", done_n, prod_at_done);
        chk("ignore_start_done_count", 32'(done_n), 32'd1);
        chk("ignore_start_product", prod_at_done, 32'd6);

        // start held high: captures land WIDTH+2 cycles apart
        drive(4, 1'b1, 1'b0, 3, 3);
        prev_busy = 1'b0; rise0 = -1; rise1 = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus4.busy && !prev_busy) begin
                if (rise0 < 0) rise0 = c;
                else if (rise1 < 0) rise1 = c;
            end
            prev_busy = bus4.busy;
        end
        drive(4, 1'b0, 1'b0, 0, 0);
        repeat (8) @(negedge clk);
        $display("op held_start w=4 capture interval %0d", rise1 - rise0);
        chk("held_start_interval", 32'(rise1 - rise0), 32'd6);

        // abort by reset during RUN
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 6, 7);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus4.busy), 32'd0);
        chk("abort_done", 32'(bus4.done), 32'd0);
        chk("abort_product", 32'(bus4.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus4.done) done_n++;
        end
        $display("op abort w=4 done pulses %0d product 0x%0h", done_n, bus4.product);
        chk("abort_no_done", 32'(done_n), 32'd0);
        chk("abort_product_after", 32'(bus4.product), 32'd0);
        run_op(4, 1'b0, 3, 5, "after_abort", 1'b1);

        run_op(8, 1'b0, 255, 255, "u8_max", 1'b1);
        chk("u8_max_const", obs_prod(8), 32'hFE01);
        run_op(8, 1'b1, 128, 127, "s8_mix", 1'b1);
        chk("s8_mix_const", obs_prod(8), 32'hC080);

        for (int i = 0; i < 1000; i++)
            run_op(4, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), "rnd4", 1'b0);
        for (int i = 0; i < 1000; i++)
            run_op(8, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), "rnd8", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
